// File: rtl/sram_word_bridge.sv
// sram_word_bridge: splits one 32-bit CPU load/store into two 16-bit
// asynchronous SRAM halfword accesses (low half first, then high half).
// Store phases whose byte enables are both clear are skipped. Loads
// return data over a one-cycle cpu_ready pulse.
module sram_word_bridge #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_be,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_busy,
    output logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data,
    output logic              wre,
    output logic              oute,
    output logic              hb_mask,
    output logic              lb_mask,
    output logic              chip_en
);

    // Phase counter wide enough to count 0..WAIT_CYCLES-1.
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Latched copy of the accepted request.
    logic                we_q, we_d;
    logic [ADDR_W-2:0]   word_q, word_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          be_q, be_d;

    // Registered CPU-side and bus-side outputs.
    logic [31:0]         rdata_q, rdata_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                wre_q, wre_d;
    logic                oute_q, oute_d;
    logic                hb_q, hb_d;
    logic                lb_q, lb_d;
    logic                ce_q, ce_d;

    logic                phase_last;

    // Address bits outside the halfword range alias by design.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+1], cpu_addr[1:0]};

    // Next-state, request latch, read capture and registered-output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        word_d     = word_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        rdata_d    = rdata_q;
        phase_last = (cnt_q == CNT_LAST);

        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    we_d    = cpu_we;
                    word_d  = cpu_addr[ADDR_W:2];
                    wdata_d = cpu_wdata;
                    be_d    = cpu_be;
                    cnt_d   = '0;
                    if (!cpu_we || (|cpu_be[1:0])) begin
                        state_d = S_LO;
                    end else if (|cpu_be[3:2]) begin
                        state_d = S_HI;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LO: begin
                if (phase_last) begin
                    if (!we_q) begin
                        rdata_d[DATA_W-1:0] = data;
                    end
                    cnt_d   = '0;
                    state_d = (!we_q || (|be_q[3:2])) ? S_HI : S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HI: begin
                if (phase_last) begin
                    if (!we_q) begin
                        rdata_d[2*DATA_W-1:DATA_W] = data;
                    end
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs follow the state being entered so they line up with it.
        addr_d  = '0;
        dout_d  = '0;
        wre_d   = 1'b1;
        oute_d  = 1'b1;
        hb_d    = 1'b1;
        lb_d    = 1'b1;
        ce_d    = 1'b1;
        ready_d = (state_d == S_DONE);
        busy_d  = (state_d != S_IDLE);

        case (state_d)
            S_LO: begin
                addr_d = {word_d, 1'b0};
                ce_d   = 1'b0;
                if (we_d) begin
                    wre_d  = 1'b0;
                    dout_d = wdata_d[DATA_W-1:0];
                    lb_d   = ~be_d[0];
                    hb_d   = ~be_d[1];
                end else begin
                    oute_d = 1'b0;
                    lb_d   = 1'b0;
                    hb_d   = 1'b0;
                end
            end
            S_HI: begin
                addr_d = {word_d, 1'b1};
                ce_d   = 1'b0;
                if (we_d) begin
                    wre_d  = 1'b0;
                    dout_d = wdata_d[2*DATA_W-1:DATA_W];
                    lb_d   = ~be_d[2];
                    hb_d   = ~be_d[3];
                end else begin
                    oute_d = 1'b0;
                    lb_d   = 1'b0;
                    hb_d   = 1'b0;
                end
            end
            default: begin
                addr_d = '0;
            end
        endcase
    end

    // State and output registers; reset returns everything to idle values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            word_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
            wre_q   <= 1'b1;
            oute_q  <= 1'b1;
            hb_q    <= 1'b1;
            lb_q    <= 1'b1;
            ce_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            wre_q   <= wre_d;
            oute_q  <= oute_d;
            hb_q    <= hb_d;
            lb_q    <= lb_d;
            ce_q    <= ce_d;
        end
    end

    // The data bus is only driven while a store phase holds wre low.
    assign data      = wre_q ? {DATA_W{1'bz}} : dout_q;

    assign cpu_rdata = rdata_q;
    assign cpu_ready = ready_q;
    assign cpu_busy  = busy_q;
    assign addr      = addr_q;
    assign wre       = wre_q;
    assign oute      = oute_q;
    assign hb_mask   = hb_q;
    assign lb_mask   = lb_q;
    assign chip_en   = ce_q;

endmodule
